// File: rtl/ext_bus_responder.sv
// Responder end of the 32-bit external memory bus: decodes command words and runs
// wrapping bursts against an internal word array, with read latency and injected stalls.
module ext_bus_responder #(
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 4,
  parameter int RD_LAT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_busEn,
  input  logic        IN_busOEn,
  input  logic [31:0] IN_bus,
  input  logic        IN_stallInject,
  output logic [31:0] OUT_bus,
  output logic        OUT_busStall
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam int LW = $clog2(RD_LAT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RD      = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [BW-1:0] r_cnt;
  logic [LW-1:0] r_lat;
  logic [31:0]   r_out;
  logic          r_stall;
  logic [31:0]   r_mem [DEPTH];

  logic          w_beat;
  logic          w_last;
  logic [BW-1:0] w_wr_off;
  logic [AW-1:0] w_wr_idx;
  logic [BW-1:0] w_rd_cnt;
  logic [BW-1:0] w_rd_off;
  logic [AW-1:0] w_rd_idx;
  logic          w_mem_we;
  logic          w_rd_load;

  // A beat completes only when the master is active and we did not flag a stall.
  assign w_beat   = IN_busEn && !r_stall;
  assign w_last   = (r_cnt == BW'(BURST_LEN - 1));

  // Critical-word-first: the low address bits wrap inside the aligned burst block.
  assign w_wr_off = r_addr[BW-1:0] + r_cnt;
  assign w_wr_idx = {r_addr[AW-1:BW], w_wr_off};

  assign w_rd_cnt = (r_state == S_RD && w_beat) ? r_cnt + BW'(1) : r_cnt;
  assign w_rd_off = r_addr[BW-1:0] + w_rd_cnt;
  assign w_rd_idx = {r_addr[AW-1:BW], w_rd_off};

  assign w_mem_we = (r_state == S_WRITE) && w_beat;

  // Fetch the word for the next RD cycle unless stalled or the burst just ended.
  assign w_rd_load = IN_busEn && !IN_stallInject &&
                     (((r_state == S_RD_WAIT) && (r_lat == LW'(1))) ||
                      ((r_state == S_RD) && !(w_beat && w_last)));

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wr_idx] <= IN_bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_out   <= '0;
      r_stall <= 1'b0;
    end else begin
      if (w_rd_load) begin
        r_out <= r_mem[w_rd_idx];
      end
      case (r_state)
        S_IDLE: begin
          r_stall <= 1'b0;
          if (IN_busEn && IN_busOEn) begin
            r_addr <= IN_bus[AW-1:0];
            r_cnt  <= '0;
            if (IN_bus[31]) begin
              r_state <= S_WRITE;
              r_stall <= IN_stallInject;
            end else begin
              r_state <= S_RD_WAIT;
              r_lat   <= LW'(RD_LAT);
              r_stall <= 1'b1;
            end
          end
        end
        S_WRITE, S_RD: begin
          if (!IN_busEn || (w_beat && w_last)) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
          end else begin
            if (w_beat) begin
              r_cnt <= r_cnt + BW'(1);
            end
            r_stall <= IN_stallInject;
          end
        end
        S_RD_WAIT: begin
          if (!IN_busEn) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
          end else if (r_lat == LW'(1)) begin
            r_state <= S_RD;
            r_stall <= IN_stallInject;
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign OUT_bus      = r_out;
  assign OUT_busStall = r_stall;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench for ext_bus_responder: writes, wrapped reads, stalls, abort, reset, aliasing.
module tb_ext_bus_responder;

  localparam int RD_LAT = 3;

  logic        clk;
  logic        rst;
  logic        IN_busEn;
  logic        IN_busOEn;
  logic [31:0] IN_bus;
  logic        IN_stallInject;
  logic [31:0] OUT_bus;
  logic        OUT_busStall;

  int total = 0;
  int bad   = 0;

  ext_bus_responder #(.DEPTH(1024), .BURST_LEN(4), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_busEn      (IN_busEn),
    .IN_busOEn     (IN_busOEn),
    .IN_bus        (IN_bus),
    .IN_stallInject(IN_stallInject),
    .OUT_bus       (OUT_bus),
    .OUT_busStall  (OUT_busStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IN_busEn       = 1'b0;
    IN_busOEn      = 1'b0;
    IN_bus         = '0;
    IN_stallInject = 1'b0;
  endtask

  // nbeats < 4 aborts by dropping IN_busEn; sb selects a beat during which a stall is injected.
  task automatic wr_burst(input logic [29:0] a, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input int nbeats, input int sb);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    IN_busEn  = 1'b1;
    IN_busOEn = 1'b1;
    IN_bus    = {2'b10, a};
    tick();
    for (int k = 0; k < nbeats; k++) begin
      IN_bus = d[k];
      chk($sformatf("wr_rdy%0d", k), {31'd0, OUT_busStall}, 32'd0);
      if (k == sb) begin
        IN_stallInject = 1'b1;
        tick();
        IN_stallInject = 1'b0;
        IN_bus = 32'hDEAD_BEEF;
        chk("wr_stall", {31'd0, OUT_busStall}, 32'd1);
      end
      tick();
    end
    if (nbeats < 4) begin
      idle();
      tick();
    end
    $display("txn write addr=%h beats=%0d stall_beat=%0d", a, nbeats, sb);
  endtask

  task automatic rd_burst(input logic [29:0] a, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3, input int sb);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    IN_busEn  = 1'b1;
    IN_busOEn = 1'b1;
    IN_bus    = {2'b00, a};
    tick();
    IN_busOEn = 1'b0;
    IN_bus    = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      chk($sformatf("rd_wait%0d", i), {31'd0, OUT_busStall}, 32'd1);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd_vld%0d", k), {31'd0, OUT_busStall}, 32'd0);
      chk($sformatf("rd_dat%0d", k), OUT_bus, e[k]);
      if (k == sb) begin
        IN_stallInject = 1'b1;
        tick();
        IN_stallInject = 1'b0;
        chk("rd_stall", {31'd0, OUT_busStall}, 32'd1);
        chk("rd_hold", OUT_bus, e[k]);
      end
      tick();
    end
    chk("rd_end_idle", {31'd0, OUT_busStall}, 32'd0);
    chk("rd_keep", OUT_bus, e[3]);
    $display("txn read  addr=%h data=%h %h %h %h stall_beat=%0d", a, e0, e1, e2, e3, sb);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_bus", OUT_bus, 32'd0);
    chk("rst_stall", {31'd0, OUT_busStall}, 32'd0);
    rst = 1'b1;
    tick();

    // Write then immediately read back with wrap; no idle gap between them.
    wr_burst(30'h10, 32'h11, 32'h22, 32'h33, 32'h44, 4, -1);
    rd_burst(30'h12, 32'h33, 32'h44, 32'h11, 32'h22, -1);
    idle();
    tick();

    rd_burst(30'h12, 32'h33, 32'h44, 32'h11, 32'h22, 0);
    idle();
    tick();

    // Prefill the 0x20 block, then abort a second write after two beats.
    wr_burst(30'h20, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 4, -1);
    wr_burst(30'h20, 32'h01, 32'h02, 32'h03, 32'h04, 2, -1);
    chk("abort_idle", {31'd0, OUT_busStall}, 32'd0);
    rd_burst(30'h20, 32'h01, 32'h02, 32'hCC, 32'hDD, -1);
    idle();
    tick();

    // Write with an injected stall; the held junk must not land in memory.
    wr_burst(30'h31, 32'h5A, 32'h6B, 32'h7C, 32'h8D, 4, 1);
    rd_burst(30'h30, 32'h8D, 32'h5A, 32'h6B, 32'h7C, 2);
    idle();
    tick();

    // Asynchronous reset during RD_WAIT.
    IN_busEn  = 1'b1;
    IN_busOEn = 1'b1;
    IN_bus    = 32'h0000_0010;
    tick();
    IN_busOEn = 1'b0;
    chk("pre_rst_stall", {31'd0, OUT_busStall}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_stall", {31'd0, OUT_busStall}, 32'd0);
    chk("async_rst_bus", OUT_bus, 32'd0);
    $display("txn reset during RD_WAIT");
    tick();
    rst = 1'b1;
    idle();
    tick();

    // 0x410 aliases index 0x10 with 1024 words; array survived the reset.
    rd_burst(30'h410, 32'h11, 32'h22, 32'h33, 32'h44, -1);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
